// File: rtl/wb_crossbar_arbiter.sv
// rtl/wb_crossbar_arbiter.sv - per-slave round-robin grant arbiter for the Wishbone crossbar
// Optional feature: define WB_ARBITER_TIMEOUT_EN to revoke grants after TIMEOUT cycles without ack.
module wb_crossbar_arbiter #(
  parameter int NM      = 2,
  parameter int NS      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NM-1:0][NS-1:0]  i_request,
  input  logic [NS-1:0]          i_s_ack,
  output logic [NM-1:0][NS-1:0]  o_granted,
  output logic [NS-1:0]          o_s_allocated,
  output logic [NS-1:0]          o_timeout
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {ST_IDLE, ST_GRANTED} state_t;

  state_t        state   [NS];
  logic [PW-1:0] ptr     [NS];
  logic [PW-1:0] owner   [NS];
  logic [PW-1:0] sel     [NS];
  logic [PW-1:0] ptr_nxt [NS];
  logic          found   [NS];
  logic          hold    [NS];
  logic          busy    [NS];

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  logic [CW-1:0] cnt [NS];
`else
  logic unused_cfg;
  assign unused_cfg = ^{i_s_ack, (TIMEOUT > 0)};
`endif

  // Round-robin search per slave starting at its pointer, plus owner-hold and column-busy terms
  always_comb begin
    logic          f;
    logic          b;
    logic [PW-1:0] sl;
    logic [PW-1:0] idx;
    for (int s = 0; s < NS; s++) begin
      f  = 1'b0;
      b  = 1'b0;
      sl = '0;
      for (int k = 0; k < NM; k++) begin
        idx = PW'((int'(ptr[s]) + k) % NM);
        if (!f && i_request[idx][s]) begin
          f  = 1'b1;
          sl = idx;
        end
      end
      for (int m = 0; m < NM; m++) begin
        b = b | o_granted[m][s];
      end
      found[s]   = f;
      sel[s]     = sl;
      busy[s]    = b;
      ptr_nxt[s] = PW'((int'(sl) + 1) % NM);
      hold[s]    = i_request[owner[s]][s];
    end
  end

  // Per-slave grant FSM; grant matrix, allocation and timeout pulses are all registered here
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_granted     <= '0;
      o_s_allocated <= '0;
      o_timeout     <= '0;
      for (int s = 0; s < NS; s++) begin
        state[s] <= ST_IDLE;
        ptr[s]   <= '0;
        owner[s] <= '0;
`ifdef WB_ARBITER_TIMEOUT_EN
        cnt[s]   <= '0;
`endif
      end
    end else begin
      o_timeout <= '0;
      for (int s = 0; s < NS; s++) begin
        o_s_allocated[s] <= busy[s];
        case (state[s])
          ST_IDLE: begin
`ifdef WB_ARBITER_TIMEOUT_EN
            cnt[s] <= '0;
`endif
            if (found[s]) begin
              o_granted[sel[s]][s] <= 1'b1;
              owner[s]             <= sel[s];
              ptr[s]               <= ptr_nxt[s];
              state[s]             <= ST_GRANTED;
            end
          end
          ST_GRANTED: begin
`ifdef WB_ARBITER_TIMEOUT_EN
            if (cnt[s] == TMAX) begin
              o_granted[owner[s]][s] <= 1'b0;
              o_timeout[s]           <= 1'b1;
              state[s]               <= ST_IDLE;
            end else if (!hold[s]) begin
              o_granted[owner[s]][s] <= 1'b0;
              state[s]               <= ST_IDLE;
            end else if (i_s_ack[s]) begin
              cnt[s] <= '0;
            end else begin
              cnt[s] <= cnt[s] + 1'b1;
            end
`else
            if (!hold[s]) begin
              o_granted[owner[s]][s] <= 1'b0;
              state[s]               <= ST_IDLE;
            end
`endif
          end
          default: state[s] <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
